// File: rtl/tt_um_serial_subtractor.sv
// rtl/tt_um_serial_subtractor.sv - bit-serial 4-bit subtractor TinyTapeout tile
//
// Computes A - B one bit per clock, LSB first, with one full-subtractor cell
// and a registered borrow. A rising edge on uio_in[0] loads the operands and
// starts a 4-clock run; the result holds until the next start or reset.
//
// Ports:
//   clk      tile clock
//   rst_n    asynchronous active-low reset
//   ena      tile enable; 0 freezes every register
//   ui_in    [3:0] operand A, [7:4] operand B (sampled at load only)
//   uio_in   [0] start (level, rising edge detected), [7:1] unused
//   uo_out   [3:0] difference, [4] borrow out, [5] busy, [6] done,
//            [7] serial difference bit
//   uio_out  tied 0
//   uio_oe   tied 0 (all uio pins are inputs)

module tt_um_serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic               start_q;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   d_sh;
    logic               borrow;
    logic [CNT_W-1:0]   cnt;

    // Registered outputs: the visible result is only updated on the final
    // step, so uo_out[4:0] stay 0 throughout RUN.
    logic               ser_q;
    logic [WIDTH-1:0]   diff_q;
    logic               bout_q;
    logic               busy_q;
    logic               done_q;

    logic               start_pulse;
    logic               d_bit;
    logic               borrow_nxt;
    logic [WIDTH-1:0]   d_sh_nxt;

    assign start_pulse = uio_in[0] & ~start_q;

    // Full-subtractor cell on the current LSBs.
    assign d_bit      = a_sh[0] ^ b_sh[0] ^ borrow;
    assign borrow_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow);
    assign d_sh_nxt   = {d_bit, d_sh[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            start_q <= 1'b0;
            a_sh    <= '0;
            b_sh    <= '0;
            d_sh    <= '0;
            borrow  <= 1'b0;
            cnt     <= '0;
            ser_q   <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (ena) begin
            start_q <= uio_in[0];
            case (state)
                IDLE, DONE: begin
                    if (start_pulse) begin
                        a_sh   <= ui_in[WIDTH-1:0];
                        b_sh   <= ui_in[2*WIDTH-1:WIDTH];
                        d_sh   <= '0;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        diff_q <= '0;
                        bout_q <= 1'b0;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    // start_pulse is deliberately ignored here.
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    d_sh   <= d_sh_nxt;
                    borrow <= borrow_nxt;
                    ser_q  <= d_bit;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        diff_q <= d_sh_nxt;
                        bout_q <= borrow_nxt;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign uo_out  = {ser_q, done_q, busy_q, bout_q, diff_q};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    logic unused_uio;
    assign unused_uio = &{1'b0, uio_in[7:1]};

endmodule

// File: tb/tb_tt_um_serial_subtractor.sv
// tb/tb_tt_um_serial_subtractor.sv - scoreboard testbench for tt_um_serial_subtractor

module tb_tt_um_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    tt_um_serial_subtractor dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] diff;
        logic       bout;
        int         due;
    } exp_t;

    exp_t exp_q[$];
    logic ser_exp[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic ena_seen = 1'b1;
    logic prev_busy = 1'b0;
    logic prev_done = 1'b0;

    always @(posedge clk) begin
        cyc++;
        ena_seen = ena;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, compares against the queues.
    always @(negedge clk) begin
        exp_t e;
        logic sb;
        if (!rst_n) begin
            prev_busy = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (prev_busy && ena_seen) begin
                if (ser_exp.size() == 0) begin
                    check("serial_unexpected", 1, 0);
                end else begin
                    sb = ser_exp.pop_front();
                    check("serial_bit", int'(uo_out[7]), int'(sb));
                end
            end
            if (uo_out[5]) begin
                check("result_zero_while_busy", int'(uo_out[4:0]), 0);
                check("not_done_while_busy", int'(uo_out[6]), 0);
            end
            if (uo_out[6] && !prev_done) begin
                if (exp_q.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("diff", int'(uo_out[3:0]), int'(e.diff));
                    check("borrow", int'(uo_out[4]), int'(e.bout));
                    check("latency", cyc, e.due);
                end
            end
            prev_busy = uo_out[5];
            prev_done = uo_out[6];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Call one cycle before the start edge; extra = clocks with ena low.
    task automatic push_exp(input logic [3:0] d, input logic b, input int extra);
        exp_t e;
        e.diff = d;
        e.bout = b;
        e.due  = cyc + 5 + extra;
        exp_q.push_back(e);
        for (int i = 0; i < 4; i++) ser_exp.push_back(d[i]);
    endtask

    task automatic launch(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] d, input logic bo);
        ui_in = {b, a};
        push_exp(d, bo, 0);
        uio_in[0] = 1'b1;
        tick();
        uio_in[0] = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20 && !uo_out[6]; i++) tick();
        if (!uo_out[6]) check("done_timeout", 0, 1);
        tick();
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] d;
        logic       bo;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{4'd9,  4'd3,  4'd6,  1'b0};
        vecs[1] = '{4'd3,  4'd9,  4'd10, 1'b1};
        vecs[2] = '{4'd15, 4'd15, 4'd0,  1'b0};
        vecs[3] = '{4'd0,  4'd0,  4'd0,  1'b0};
        vecs[4] = '{4'd0,  4'd1,  4'd15, 1'b1};

        #2;
        check("reset_uo_out", int'(uo_out), 0);
        check("reset_uio_out", int'(uio_out), 0);
        check("reset_uio_oe", int'(uio_oe), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_after_reset", int'(uo_out), 0);

        // Directed vectors
        foreach (vecs[i]) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bo);
            wait_done();
        end

        // Start pulse and operand change during RUN are ignored
        launch(4'd9, 4'd3, 4'd6, 1'b0);
        tick();
        ui_in = {4'd8, 4'd1};
        uio_in[0] = 1'b1;
        tick();
        uio_in[0] = 1'b0;
        wait_done();
        check("hold_diff", int'(uo_out[3:0]), 6);

        // Start held high: exactly one operation
        ui_in = {4'd2, 4'd7};
        push_exp(4'd5, 1'b0, 0);
        uio_in[0] = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("held_done", int'(uo_out[6]), 1);
        check("held_diff", int'(uo_out[3:0]), 5);
        uio_in[0] = 1'b0;
        tick();
        tick();

        // Asynchronous reset mid-RUN
        launch(4'd9, 4'd3, 4'd6, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("async_reset_uo_out", int'(uo_out), 0);
        exp_q.delete();
        ser_exp.delete();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_after_abort", int'(uo_out), 0);

        // ena low for 3 clocks mid-RUN
        ui_in = {4'd3, 4'd12};
        push_exp(4'd9, 1'b0, 3);
        uio_in[0] = 1'b1;
        tick();
        uio_in[0] = 1'b0;
        tick();
        ena = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("frozen_busy", int'(uo_out[5]), 1);
        ena = 1'b1;
        wait_done();

        // Exhaustive sweep against the reference model
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                launch(4'(a), 4'(b), 4'((a - b) & 15), (a < b));
                wait_done();
            end
        end

        tick();
        check("expected_left", exp_q.size(), 0);
        check("serial_left", ser_exp.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
